// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide for mult/div: radix-2 Booth multiply, restoring divide, one step per clock.
// Optional MULTDIV_UNSIGNED_EN adds op_unsigned for multu/divu.
//
// state  | meaning
// IDLE   | waiting for start; operands latched on start
// MULT   | Booth iterations, WIDTH cycles
// DIV    | restoring-divide iterations on magnitudes, WIDTH cycles
// FINISH | sign correction, load HI/LO
// DONE   | result valid; done/div_zero appear on the following cycle
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
`ifdef MULTDIV_UNSIGNED_EN
  input  logic             op_unsigned,
`endif
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FINISH, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               div_q, div_d, uns_q, uns_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic               in_uns, in_a_neg, a_neg, b_neg;
  logic [WIDTH-1:0]   b_mag, quo_fix, rem_fix, prod_hi_fix, corr_a, corr_b;
  logic [WIDTH:0]     p_ext, a_ext, booth_sum, r_sh;
  logic               ge;

`ifdef MULTDIV_UNSIGNED_EN
  assign in_uns = op_unsigned;
`else
  assign in_uns = 1'b0;
`endif

  assign in_a_neg = !in_uns && operand_a[WIDTH-1];
  assign a_neg    = !uns_q && a_q[WIDTH-1];
  assign b_neg    = !uns_q && b_q[WIDTH-1];
  assign b_mag    = b_neg ? -b_q : b_q;

  // Sum is kept one bit wider so the shift sees the true sign even when a = -2^(WIDTH-1).
  assign p_ext = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
  assign a_ext = {a_q[WIDTH-1], a_q};
  always_comb begin
    booth_sum = p_ext;
    case (acc_q[1:0])
      2'b01:   booth_sum = p_ext + a_ext;
      2'b10:   booth_sum = p_ext - a_ext;
      default: booth_sum = p_ext;
    endcase
  end

  assign r_sh = {rem_q, quo_q[WIDTH-1]};
  assign ge   = r_sh >= {1'b0, b_mag};

  assign quo_fix = (a_neg != b_neg) ? -quo_q : quo_q;
  assign rem_fix = a_neg ? -rem_q : rem_q;
  // Unsigned product from the signed one: add back the 2^WIDTH terms of each operand's top bit.
  assign corr_a      = (uns_q && a_q[WIDTH-1]) ? b_q : '0;
  assign corr_b      = (uns_q && b_q[WIDTH-1]) ? a_q : '0;
  assign prod_hi_fix = acc_q[2*WIDTH:WIDTH+1] + corr_a + corr_b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    div_d   = div_q;
    uns_d   = uns_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = (state_q == S_MULT) || (state_q == S_DIV) || (state_q == S_FINISH);
    done_d  = (state_q == S_DONE);
    dz_d    = (state_q == S_DONE) && div_q && (b_q == '0);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = operand_a;
          b_d   = operand_b;
          div_d = op_div;
          uns_d = in_uns;
          cnt_d = '0;
          acc_d = {{WIDTH{1'b0}}, operand_b, 1'b0};
          rem_d = '0;
          quo_d = in_a_neg ? -operand_a : operand_a;
          if (!op_div)                state_d = S_MULT;
          else if (operand_b != '0)   state_d = S_DIV;
          else                        state_d = S_DONE;
        end
      end
      S_MULT: begin
        acc_d = {booth_sum, acc_q[WIDTH:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          cnt_d   = '0;
          state_d = S_FINISH;
        end
      end
      S_DIV: begin
        rem_d = ge ? (r_sh[WIDTH-1:0] - b_mag) : r_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          cnt_d   = '0;
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        if (div_q) begin
          lo_d = uns_q ? quo_q : quo_fix;
          hi_d = uns_q ? rem_q : rem_fix;
        end else begin
          lo_d = acc_q[WIDTH:1];
          hi_d = prod_hi_fix;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      uns_q   <= 1'b0;
      acc_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      div_q   <= div_d;
      uns_q   <= uns_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized bench for mult_div_unit against a plain 64-bit arithmetic reference model.
// Define MULTDIV_UNSIGNED_EN to also exercise multu/divu.
module tb_mult_div_unit;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset, start, op_div;
  logic          op_unsigned;
  logic [W-1:0]  operand_a, operand_b;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [W-1:0]  exp_hi, exp_lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op_div    (op_div),
`ifdef MULTDIV_UNSIGNED_EN
    .op_unsigned(op_unsigned),
`endif
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  // Reference: 64-bit products, truncating division, remainder follows dividend.
  task automatic model(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic uns, output logic [W-1:0] eh, output logic [W-1:0] el);
    longint       sa, sb, q, r;
    logic [63:0]  p, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_div) begin
      if (uns) p = {32'b0, a} * {32'b0, b};
      else     p = sa * sb;
      eh = p[63:32];
      el = p[31:0];
    end else if (b == '0) begin
      eh = exp_hi;
      el = exp_lo;
    end else if (uns) begin
      el = a / b;
      eh = a % b;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      qv = q;
      rv = r;
      el = qv[31:0];
      eh = rv[31:0];
    end
  endtask

  task automatic run_op(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic uns, input logic poke);
    logic [W-1:0] eh, el;
    logic         dz, seen, dz_obs;
    int           lat, busy_cnt;
    model(is_div, a, b, uns, eh, el);
    dz       = is_div && (b == '0);
    seen     = 1'b0;
    dz_obs   = 1'b0;
    lat      = -1;
    busy_cnt = 0;
    @(negedge clock);
    start       = 1'b1;
    op_div      = is_div;
    operand_a   = a;
    operand_b   = b;
    op_unsigned = uns;
    @(posedge clock);
    for (int e = 0; e < 100 && !seen; e++) begin
      @(negedge clock);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        seen   = 1'b1;
        lat    = e;
        dz_obs = div_zero;
      end
      if (e == 0) begin
        start     = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        op_div    = 1'($urandom_range(0, 1));
      end
      if (poke && e == 10) begin
        start     = 1'b1;
        op_div    = 1'b1;
        operand_b = '0;
      end
      if (poke && e == 11) start = 1'b0;
    end
    start = 1'b0;
    chk("done_seen", 64'(seen), 64'd1);
    chk("latency", 64'(lat), dz ? 64'd1 : 64'(W + 2));
    chk("busy_cycles", 64'(busy_cnt), dz ? 64'd0 : 64'(W + 1));
    chk("div_zero", 64'(dz_obs), 64'(dz));
    chk("hi", 64'(hi), 64'(eh));
    chk("lo", 64'(lo), 64'(el));
    @(negedge clock);
    chk("done_pulse", 64'(done), 64'd0);
    exp_hi = eh;
    exp_lo = el;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rd, ru;
    reset       = 1'b1;
    start       = 1'b0;
    op_div      = 1'b0;
    op_unsigned = 1'b0;
    operand_a   = '0;
    operand_b   = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    reset  = 1'b0;
    exp_hi = '0;
    exp_lo = '0;

    run_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
    run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op(1'b1, 32'h0000_0671, 32'h0000_0030, 1'b0, 1'b0);
    chk("pre_dz_hi", 64'(hi), 64'h11);
    chk("pre_dz_lo", 64'(lo), 64'h22);
    run_op(1'b1, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0);
    run_op(1'b0, 32'h1234_5678, 32'hFEDC_BA98, 1'b0, 1'b1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0);

    @(negedge clock);
    start     = 1'b1;
    op_div    = 1'b1;
    operand_a = 32'h7654_3210;
    operand_b = 32'h0000_0013;
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_hi", 64'(hi), 64'd0);
    chk("mid_rst_lo", 64'(lo), 64'd0);
    reset  = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rd = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 9));
        1:       rb = -32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
`ifdef MULTDIV_UNSIGNED_EN
      ru = 1'($urandom_range(0, 1));
`else
      ru = 1'b0;
`endif
      run_op(rd, ra, rb, ru, 1'b0);
    end

`ifdef MULTDIV_UNSIGNED_EN
    run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0);
    run_op(1'b0, 32'h8000_0001, 32'hFFFF_FFF0, 1'b1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative signed multiply/divide unit for MIPS mult/div, placed beside the ALU in the multicycle datapath.
- It consumes the A and B operand registers and produces HI/LO, which feed the write-back mux for mfhi/mflo.
- The control FSM pulses start, then waits in a stall state until done.
- The unit uses a radix-2 Booth multiply and a restoring divide, with one iteration per clock.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  launch request; sampled only in IDLE.
- op_div  in  1  operation select: 0 = multiply, 1 = divide; sampled with start.
- operand_a  in  WIDTH  multiplicand or dividend (register A output).
- operand_b  in  WIDTH  multiplier or divisor (register B output).
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when HI/LO (or div_zero) are valid.
- div_zero  out  1  one-cycle pulse together with done when a divide had divisor 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: state = IDLE; hi = lo = 0; busy = done = div_zero = 0; iteration counter = 0.
- Reset asserted mid-operation aborts the operation and applies the same reset values at the next edge.
- States: IDLE, MULT, DIV, FINISH, DONE.
- IDLE:
  - If start = 1 at edge k, latch operand_a, operand_b and op_div, clear the counter, and set busy = 1 from k+1.
  - Go to MULT when op_div = 0.
  - Go to DIV when op_div = 1 and operand_b != 0.
  - Go to DONE when op_div = 1 and operand_b == 0.
- Inputs are sampled only at the start edge; later changes to operand_a/operand_b are ignored. start in any state other than IDLE is ignored.
- MULT:
  - Booth radix-2 over a 2*WIDTH+1 bit accumulator; one add/sub plus arithmetic shift right per cycle.
  - Exactly WIDTH cycles, then go to FINISH.
- DIV:
  - Restoring division on the magnitudes |a| and |b|; one shift/subtract per cycle.
  - Exactly WIDTH cycles, then go to FINISH.
- FINISH:
  - Multiply: {hi, lo} is loaded with the signed 2*WIDTH-bit product.
  - Divide: lo is the quotient truncated toward zero, negated if the signs of a and b differ.
  - Divide: hi is the remainder, carrying the sign of the dividend.
  - Go to DONE.
- DONE: done = 1 for exactly one cycle; busy = 0 in that same cycle; return to IDLE.
- Latency: with start at edge k, done is high in the cycle after edge k+WIDTH+2, for both mult and div.
- Divide by zero:
  - The unit goes IDLE -> DONE, so done and div_zero are high in the cycle after edge k+1.
  - hi and lo keep their previous values.
- Overflow: -2^(WIDTH-1) / -1 gives lo = 0x80000000 and hi = 0, with no flag raised.
- hi and lo change only in FINISH or on reset; they hold between operations.
- start may be asserted in the DONE cycle, but it is not accepted until the following IDLE cycle.

Optional Feature:
- Macro: MULTDIV_UNSIGNED_EN.
- When defined:
  - An extra input op_unsigned (1 bit) is sampled with start.
  - When op_unsigned = 1, operands are treated as unsigned (multu/divu): no sign correction, and the product is zero-extended.
  - Latency is unchanged.
- When undefined: the port is absent and all operations are signed.

Test Plan:
- mult 7 * -3 (0x00000007, 0xFFFFFFFD), start at edge 0 -> done in the cycle after edge 34; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; busy high during cycles 1..33.
- div -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; div 7 / -2 -> lo = 0xFFFFFFFD, hi = 0x00000001.
- div 5 / 0 with prior hi = 0x11, lo = 0x22 -> done and div_zero pulse after 2 edges; hi/lo remain 0x11/0x22.
- Start a mult, then pulse start with a div at cycle 10 -> the second start is ignored; the mult result appears at edge 34 and div_zero stays 0.
- Reset asserted at cycle 15 of a div -> next cycle busy = 0, hi = lo = 0; a new mult 0x80000000 * 0x80000000 gives hi = 0x40000000, lo = 0.
- With MULTDIV_UNSIGNED_EN: multu 0xFFFFFFFF * 2 -> hi = 1, lo = 0xFFFFFFFE; divu 0xFFFFFFFF / 2 -> lo = 0x7FFFFFFF, hi = 1.
